// File: rtl/multiword_add_sequencer_if.sv
// Operand/result handshake bundle for the multiword add sequencer.
// The master side is the producer/consumer. The slave side is the sequencer.
interface multiword_add_sequencer_if #(
    parameter int WORDS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [16*WORDS-1:0]   in_a;
    logic [16*WORDS-1:0]   in_b;
    logic                  in_cin;
    logic                  out_valid;
    logic                  out_ready;
    logic [16*WORDS-1:0]   out_sum;
    logic                  out_cout;
    logic                  out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Multiword add sequencer. It feeds a wide operand pair to an external
// 16-bit combinational adder one slice per cycle, starting with the LSW.
// The carry between slices ripples through a register.
module multiword_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    multiword_add_sequencer_if.slave      bus,
    output logic [15:0]                   add_a,
    output logic [15:0]                   add_b,
    output logic                          add_cin,
    input  logic [15:0]                   add_sum,
    input  logic                          add_cout,
    output logic                          busy
);
    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    logic [1:0]    state_reg;
    logic [IW-1:0] idx_reg;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic [W-1:0]  sum_next;
    logic [W-1:0]  out_sum_reg;
    logic          carry_reg;
    logic          cout_reg;
    logic          ovf_reg;
    logic          run;
    logic          last;
    logic          accept;

    assign run    = (state_reg == RUN);
    assign last   = run && (idx_reg == LAST_IDX);
    assign accept = (state_reg == IDLE) && bus.in_valid;

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out_sum   = out_sum_reg;
    assign bus.out_cout  = cout_reg;
    assign bus.out_ovf   = ovf_reg;
    assign busy          = (state_reg == RUN) || (state_reg == DONE);
    assign add_cin       = run ? carry_reg : 1'b0;

    // Select the current operand slices. The adder inputs are held at zero outside RUN.
    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (run && (idx_reg == IW'(i))) begin
                add_a = a_reg[16*i +: 16];
                add_b = b_reg[16*i +: 16];
            end
        end
    end

    // Merge the adder's slice result into the working sum at the active index.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_slice
            assign sum_next[16*gi +: 16] = (run && (idx_reg == IW'(gi))) ? add_sum
                                                                          : sum_reg[16*gi +: 16];
        end
    endgenerate

    // Control FSM: IDLE -> RUN (one cycle per slice) -> DONE -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_reg <= RUN;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Latch operands on accept. Ripple the slice carry while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
        end else if (accept) begin
            a_reg     <= bus.in_a;
            b_reg     <= bus.in_b;
            carry_reg <= bus.in_cin;
        end else if (run) begin
            carry_reg <= add_cout;
        end
    end

    // Accumulate slice sums while running. The published result updates only on the final slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg     <= '0;
            out_sum_reg <= '0;
            cout_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            if (run) begin
                sum_reg <= sum_next;
            end
            if (last) begin
                out_sum_reg <= sum_next;
                cout_reg    <= add_cout;
                ovf_reg     <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[15] != a_reg[W-1]);
            end
        end
    end
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard testbench for multiword_add_sequencer, covering WORDS=4 and WORDS=1.
module tb_multiword_add_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multiword_add_sequencer_if #(.WORDS(4)) bus4();
    multiword_add_sequencer_if #(.WORDS(1)) bus1();

    logic [15:0] add_a4, add_b4, add_sum4, add_a1, add_b1, add_sum1;
    logic        add_cin4, add_cout4, busy4, add_cin1, add_cout1, busy1;

    // External combinational 16-bit adders.
    assign {add_cout4, add_sum4} = 17'(add_a4) + 17'(add_b4) + 17'(add_cin4);
    assign {add_cout1, add_sum1} = 17'(add_a1) + 17'(add_b1) + 17'(add_cin1);

    multiword_add_sequencer #(.WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4),
        .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
        .add_sum(add_sum4), .add_cout(add_cout4), .busy(busy4)
    );

    multiword_add_sequencer #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
        .add_sum(add_sum1), .add_cout(add_cout1), .busy(busy1)
    );

    int checks = 0;
    int failures = 0;
    logic [65:0] q4[$];
    logic [17:0] q1[$];
    bit cin_watch = 1'b0;

    // Reference model: {ovf, cout, sum} from plain wide arithmetic.
    function automatic logic [65:0] model4(input logic [63:0] a, input logic [63:0] b, input logic cin);
        logic [64:0] full;
        full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        return {(a[63] == b[63]) && (full[63] != a[63]), full};
    endfunction

    function automatic logic [17:0] model1(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] full;
        full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        return {(a[15] == b[15]) && (full[15] != a[15]), full};
    endfunction

    function automatic logic [63:0] rand64();
        logic [63:0] v;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 3))
                0:       v[16*i +: 16] = 16'h0000;
                1:       v[16*i +: 16] = 16'hFFFF;
                default: v[16*i +: 16] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare each accepted result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus4.out_valid && bus4.out_ready) begin
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out4_unexpected actual=%h required=none", bus4.out_sum);
            end else begin
                check("out4", {bus4.out_ovf, bus4.out_cout, bus4.out_sum}, q4.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL out1_unexpected actual=%h required=none", bus1.out_sum);
            end else begin
                check("out1", {48'd0, bus1.out_ovf, bus1.out_cout, bus1.out_sum}, {48'd0, q1.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (cin_watch && busy4 && !bus4.out_valid)
            check("run_add_cin", {65'd0, add_cin4}, 66'd1);
    end

    task automatic send4(input logic [63:0] a, input logic [63:0] b, input logic cin, input bit push);
        int n = 0;
        bus4.in_a = a; bus4.in_b = b; bus4.in_cin = cin; bus4.in_valid = 1'b1;
        @(negedge clk);
        while (!bus4.in_ready && n < 200) begin @(negedge clk); n++; end
        if (!bus4.in_ready) begin
            checks++; failures++;
            $display("FAIL send4_timeout actual=in_ready_low required=in_ready_high");
        end else if (push) begin
            q4.push_back(model4(a, b, cin));
        end
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
    endtask

    task automatic send1(input logic [15:0] a, input logic [15:0] b, input logic cin);
        int n = 0;
        bus1.in_a = a; bus1.in_b = b; bus1.in_cin = cin; bus1.in_valid = 1'b1;
        @(negedge clk);
        while (!bus1.in_ready && n < 200) begin @(negedge clk); n++; end
        if (!bus1.in_ready) begin
            checks++; failures++;
            $display("FAIL send1_timeout actual=in_ready_low required=in_ready_high");
        end else begin
            q1.push_back(model1(a, b, cin));
        end
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
    endtask

    // Counts edges from the accepting edge (edge 1) until out_valid is seen.
    task automatic wait_valid4(input string name);
        int lat = 1;
        while (!bus4.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        check(name, 66'(lat), 66'd5);
    endtask

    logic [63:0] xa, xb, ya, yb;
    logic [65:0] xexp;
    logic        xc, yc;

    initial begin
        bus4.in_valid = 0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_cin = 0; bus4.out_ready = 1;
        bus1.in_valid = 0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 0; bus1.out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("reset_flags4", {60'd0, bus4.in_ready, bus4.out_valid, bus4.out_cout, bus4.out_ovf, busy4, add_cin4}, {60'd0, 6'b100000});
        check("reset_sum4", {2'b0, bus4.out_sum}, 66'd0);
        check("reset_add4", {34'd0, add_a4, add_b4}, 66'd0);
        check("reset_flags1", {60'd0, bus1.in_ready, bus1.out_valid, bus1.out_cout, bus1.out_ovf, busy1, add_cin1}, {60'd0, 6'b100000});

        // Carry ripple across a slice boundary
        send4(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b1);
        wait_valid4("ripple_latency");
        @(posedge clk); #1;

        // Full wrap with carry-in: carry stays 1 in every slice
        cin_watch = 1'b1;
        send4({64{1'b1}}, 64'd0, 1'b1, 1'b1);
        wait_valid4("wrap_latency");
        cin_watch = 1'b0;
        @(posedge clk); #1;

        // Signed overflow
        send4(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
        wait_valid4("ovf_latency");
        @(posedge clk); #1;

        // Backpressure: result holds, a second request is ignored until release
        xa = rand64(); xb = rand64(); xc = 1'($urandom);
        ya = rand64(); yb = rand64(); yc = 1'($urandom);
        xexp = model4(xa, xb, xc);
        bus4.out_ready = 1'b0;
        send4(xa, xb, xc, 1'b1);
        wait_valid4("bp_latency");
        bus4.in_a = ya; bus4.in_b = yb; bus4.in_cin = yc; bus4.in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("bp_valid", {65'd0, bus4.out_valid}, 66'd1);
            check("bp_result", {bus4.out_ovf, bus4.out_cout, bus4.out_sum}, xexp);
            check("bp_in_ready", {65'd0, bus4.in_ready}, 66'd0);
        end
        @(posedge clk); #1;
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {64'd0, bus4.in_ready, bus4.out_valid}, {64'd0, 2'b10});
        send4(ya, yb, yc, 1'b1);
        wait_valid4("bp_second_latency");
        @(posedge clk); #1;

        // Reset mid-RUN aborts with no partial result
        send4({64{1'b1}}, 64'd0, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midreset_flags", {62'd0, bus4.in_ready, bus4.out_valid, add_cin4, busy4}, {62'd0, 4'b1000});
        check("midreset_sum", {2'b0, bus4.out_sum}, 66'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("post_reset_in_ready", {65'd0, bus4.in_ready}, 66'd1);
        @(posedge clk); #1;

        // Random back-to-back operations on both widths
        fork
            begin
                for (int i = 0; i < 1000; i++) send4(rand64(), rand64(), 1'($urandom), 1'b1);
            end
            begin
                for (int i = 0; i < 1000; i++) send1(16'(rand64()), 16'(rand64()), 1'($urandom));
            end
        join

        for (int i = 0; i < 100 && (q4.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        #1;
        check("drain4", 66'(q4.size()), 66'd0);
        check("drain1", 66'(q1.size()), 66'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
